// File: rtl/fft_peak_pkg.sv
// fft_peak_pkg
// Shared types and helpers for the FFT spectral peak finder.
//   mag_width()    : width of |X|^2 for a given signed component width
//   peak_result_t  : published frame result (bin, magnitude, found flag)
//   pipe_entry_t   : control sideband travelling with a bin through S1/S2
// Struct fields are sized for the largest supported configuration; users
// slice them down to their own BIN_WIDTH / MAG_WIDTH.
package fft_peak_pkg;

  localparam int BIN_W_MAX = 16;
  localparam int MAG_W_MAX = 64;

  // re^2 + im^2 of two signed N-bit values is at most 2^(2N-1), which fits
  // an unsigned 2N-bit field.
  function automatic int mag_width(input int data_width);
    return 2 * data_width;
  endfunction

  typedef struct packed {
    logic [BIN_W_MAX-1:0] bin;
    logic [MAG_W_MAX-1:0] mag;
    logic                 found;
  } peak_result_t;

  typedef struct packed {
    logic                 valid;
    logic [BIN_W_MAX-1:0] bin;
    logic                 in_window;
    logic                 last;
  } pipe_entry_t;

endpackage

// File: rtl/mag_sq_pipe.sv
// mag_sq_pipe
// Two-stage signed squaring path with control passthrough.
//   S1 registers the raw components and the bin sideband,
//   S2 registers re^2 and im^2 alongside the sideband.
// Ports:
//   clk_i, rst_i      clock, asynchronous active-high reset (sideband only)
//   flush_i           kills the entry moving S1 -> S2 (new S1 entry still loads)
//   valid_i, bin_i, in_window_i, last_i, re_i, im_i   S1 inputs
//   valid_o, bin_o, in_window_o, last_o, re_sq_o, im_sq_o   S2 outputs
module mag_sq_pipe
  import fft_peak_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int BIN_WIDTH  = 8
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           flush_i,
  input  logic                           valid_i,
  input  logic [BIN_WIDTH-1:0]           bin_i,
  input  logic                           in_window_i,
  input  logic                           last_i,
  input  logic signed [DATA_WIDTH-1:0]   re_i,
  input  logic signed [DATA_WIDTH-1:0]   im_i,
  output logic                           valid_o,
  output logic [BIN_WIDTH-1:0]           bin_o,
  output logic                           in_window_o,
  output logic                           last_o,
  output logic signed [2*DATA_WIDTH-1:0] re_sq_o,
  output logic signed [2*DATA_WIDTH-1:0] im_sq_o
);

  localparam int SQ_W = 2 * DATA_WIDTH;

  pipe_entry_t ent_p1_d, ent_p1_q, ent_p2_d, ent_p2_q;

  logic signed [DATA_WIDTH-1:0] re_p1_q, im_p1_q;
  logic signed [SQ_W-1:0]       re_ext, im_ext;
  logic signed [SQ_W-1:0]       re_sq_p2_q, im_sq_p2_q;

  always_comb begin
    ent_p1_d           = '0;
    ent_p1_d.valid     = valid_i;
    ent_p1_d.bin       = BIN_W_MAX'(bin_i);
    ent_p1_d.in_window = in_window_i;
    ent_p1_d.last      = last_i;
    ent_p2_d           = ent_p1_q;
    ent_p2_d.valid     = ent_p1_q.valid & ~flush_i;
  end

  // S1 / S2 boundary: sideband registers
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ent_p1_q <= '0;
      ent_p2_q <= '0;
    end else begin
      ent_p1_q <= ent_p1_d;
      ent_p2_q <= ent_p2_d;
    end
  end

  // Sign-extend before multiplying so the full-width product is exact.
  assign re_ext = SQ_W'(re_p1_q);
  assign im_ext = SQ_W'(im_p1_q);

  // S1 / S2 boundary: datapath registers
  always_ff @(posedge clk_i) begin
    re_p1_q    <= re_i;
    im_p1_q    <= im_i;
    re_sq_p2_q <= re_ext * re_ext;
    im_sq_p2_q <= im_ext * im_ext;
  end

  assign valid_o     = ent_p2_q.valid;
  assign bin_o       = ent_p2_q.bin[BIN_WIDTH-1:0];
  assign in_window_o = ent_p2_q.in_window;
  assign last_o      = ent_p2_q.last;
  assign re_sq_o     = re_sq_p2_q;
  assign im_sq_o     = im_sq_p2_q;

endmodule

// File: rtl/fft_peak_finder.sv
// fft_peak_finder
// Streaming peak search over one FFT frame of complex bins.
//   clk_i, rst_i                 clock, asynchronous active-high reset
//   data_real_i, data_imag_i     signed bin components, valid_i / ready_o
//   sync_i                       restart the frame at bin 0
//   bin_lo_i, bin_hi_i           inclusive search window (latched at bin 0)
//   threshold_i                  minimum |X|^2 for peak_found_o (latched at bin 0)
//   peak_bin_o, peak_mag_o, peak_found_o, result_valid_o / result_ready_i
//   frame_count_o                completed frames, wraps
//   overrun_o                    sticky: unconsumed result overwritten
module fft_peak_finder
  import fft_peak_pkg::*;
#(
  parameter int DATA_WIDTH = 18,
  parameter int FFT_SIZE   = 256,
  parameter int BIN_WIDTH  = $clog2(FFT_SIZE),
  parameter int MAG_WIDTH  = mag_width(DATA_WIDTH),
  parameter int FCNT_WIDTH = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic signed [DATA_WIDTH-1:0] data_real_i,
  input  logic signed [DATA_WIDTH-1:0] data_imag_i,
  input  logic                         valid_i,
  output logic                         ready_o,
  input  logic                         sync_i,
  input  logic [BIN_WIDTH-1:0]         bin_lo_i,
  input  logic [BIN_WIDTH-1:0]         bin_hi_i,
  input  logic [MAG_WIDTH-1:0]         threshold_i,
  output logic [BIN_WIDTH-1:0]         peak_bin_o,
  output logic [MAG_WIDTH-1:0]         peak_mag_o,
  output logic                         peak_found_o,
  output logic                         result_valid_o,
  input  logic                         result_ready_i,
  output logic [FCNT_WIDTH-1:0]        frame_count_o,
  output logic                         overrun_o
);

  logic                  ready_q;
  logic [BIN_WIDTH-1:0]  bin_q, bin_d, acc_bin;
  logic [BIN_WIDTH-1:0]  lo_q, hi_q, lo_eff, hi_eff;
  logic [MAG_WIDTH-1:0]  thr_q;
  logic                  accept, first_bin, in_window, last_bin;

  // A sync sample is bin 0 of the new frame; bin 0 sees this cycle's window.
  assign accept    = valid_i & ready_q;
  assign acc_bin   = sync_i ? '0 : bin_q;
  assign first_bin = accept && (acc_bin == '0);
  assign lo_eff    = first_bin ? bin_lo_i : lo_q;
  assign hi_eff    = first_bin ? bin_hi_i : hi_q;
  assign in_window = (acc_bin >= lo_eff) && (acc_bin <= hi_eff);
  assign last_bin  = (acc_bin == BIN_WIDTH'(FFT_SIZE - 1));

  always_comb begin
    bin_d = bin_q;
    if (accept)      bin_d = acc_bin + BIN_WIDTH'(1);
    else if (sync_i) bin_d = '0;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ready_q <= 1'b0;
      bin_q   <= '0;
      lo_q    <= '0;
      hi_q    <= '0;
      thr_q   <= '0;
    end else begin
      ready_q <= 1'b1;
      bin_q   <= bin_d;
      if (first_bin) begin
        lo_q  <= bin_lo_i;
        hi_q  <= bin_hi_i;
        thr_q <= threshold_i;
      end
    end
  end

  logic                           p2_valid, p2_in_window, p2_last;
  logic [BIN_WIDTH-1:0]           p2_bin;
  logic signed [2*DATA_WIDTH-1:0] re_sq, im_sq;

  mag_sq_pipe #(
    .DATA_WIDTH (DATA_WIDTH),
    .BIN_WIDTH  (BIN_WIDTH)
  ) u_mag_sq (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .flush_i     (sync_i),
    .valid_i     (accept),
    .bin_i       (acc_bin),
    .in_window_i (in_window),
    .last_i      (last_bin),
    .re_i        (data_real_i),
    .im_i        (data_imag_i),
    .valid_o     (p2_valid),
    .bin_o       (p2_bin),
    .in_window_o (p2_in_window),
    .last_o      (p2_last),
    .re_sq_o     (re_sq),
    .im_sq_o     (im_sq)
  );

  logic                  have_q, have_d, have_nx;
  logic [BIN_WIDTH-1:0]  best_bin_q, best_bin_d, bbin_nx;
  logic [MAG_WIDTH-1:0]  best_mag_q, best_mag_d, bmag_nx, mag_s3;
  logic [MAG_WIDTH-1:0]  thr_cmp_q, thr_cmp_d;
  logic                  hit, take, frame_end;
  peak_result_t          res_q, res_d;
  logic                  res_valid_q, res_valid_d;
  logic [FCNT_WIDTH-1:0] fcnt_q, fcnt_d;
  logic                  overrun_q, overrun_d;

  // Both squares are non-negative, so the sum is exact as unsigned.
  assign mag_s3 = MAG_WIDTH'($unsigned(re_sq)) + MAG_WIDTH'($unsigned(im_sq));

  always_comb begin
    hit       = p2_valid && p2_in_window;
    take      = hit && (!have_q || (mag_s3 > best_mag_q));
    have_nx   = have_q | hit;
    bbin_nx   = take ? p2_bin : best_bin_q;
    bmag_nx   = take ? mag_s3 : best_mag_q;
    // thr_q may be re-latched by the next frame before this frame's last bin
    // reaches S3, so the threshold is handed over when bin 0 passes here.
    thr_cmp_d = (p2_valid && (p2_bin == '0)) ? thr_q : thr_cmp_q;
    frame_end = p2_valid && p2_last && !sync_i;

    have_d      = have_nx;
    best_bin_d  = bbin_nx;
    best_mag_d  = bmag_nx;
    res_d       = res_q;
    res_valid_d = res_valid_q;
    fcnt_d      = fcnt_q;
    overrun_d   = overrun_q;

    if (res_valid_q && result_ready_i) res_valid_d = 1'b0;

    if (sync_i || frame_end) begin
      have_d     = 1'b0;
      best_bin_d = '0;
      best_mag_d = '0;
    end

    if (frame_end) begin
      res_d.bin   = have_nx ? BIN_W_MAX'(bbin_nx) : '0;
      res_d.mag   = have_nx ? MAG_W_MAX'(bmag_nx) : '0;
      res_d.found = have_nx && (bmag_nx >= thr_cmp_d);
      res_valid_d = 1'b1;
      fcnt_d      = fcnt_q + FCNT_WIDTH'(1);
      if (res_valid_q && !result_ready_i) overrun_d = 1'b1;
    end
  end

  // S3 boundary: accumulator and result register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      have_q      <= 1'b0;
      best_bin_q  <= '0;
      best_mag_q  <= '0;
      thr_cmp_q   <= '0;
      res_q       <= '0;
      res_valid_q <= 1'b0;
      fcnt_q      <= '0;
      overrun_q   <= 1'b0;
    end else begin
      have_q      <= have_d;
      best_bin_q  <= best_bin_d;
      best_mag_q  <= best_mag_d;
      thr_cmp_q   <= thr_cmp_d;
      res_q       <= res_d;
      res_valid_q <= res_valid_d;
      fcnt_q      <= fcnt_d;
      overrun_q   <= overrun_d;
    end
  end

  assign ready_o        = ready_q;
  assign peak_bin_o     = res_q.bin[BIN_WIDTH-1:0];
  assign peak_mag_o     = res_q.mag[MAG_WIDTH-1:0];
  assign peak_found_o   = res_q.found;
  assign result_valid_o = res_valid_q;
  assign frame_count_o  = fcnt_q;
  assign overrun_o      = overrun_q;

endmodule
